// File: rtl/compositor_sprites.sv
// Raster compositor: walks the visible frame, fetches background indices, overlays
// fixed-priority rectangular sprites, maps palette indices to RGB and flags player collisions.
module compositor_sprites #(
    parameter int H_ATIVO = 640,
    parameter int V_ATIVO = 480,
    parameter int N_SPR   = 4,
    parameter int SPR_W   = 32,
    parameter int SPR_H   = 48,
    parameter int XW      = 10,
    parameter int YW      = 9,
    parameter int AW      = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_en,
    input  logic [N_SPR*XW-1:0]   spr_x,
    input  logic [N_SPR*YW-1:0]   spr_y,
    input  logic [N_SPR*3-1:0]    spr_cor,
    input  logic [N_SPR-1:0]      spr_ativo,
    output logic [AW-1:0]         endereco,
    input  logic [2:0]            fundo,
    output logic [23:0]           data_out,
    output logic                  data_valid,
    output logic                  frame_fim,
    output logic [N_SPR-2:0]      colisao
);

    localparam logic [XW-1:0] X_LAST  = XW'(H_ATIVO - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ATIVO - 1);
    localparam logic [XW:0]   SPR_W_E = (XW+1)'(SPR_W);
    localparam logic [YW:0]   SPR_H_E = (YW+1)'(SPR_H);

    function automatic logic [23:0] palette(input logic [2:0] idx);
        case (idx)
            3'd0:    return 24'h000000;
            3'd1:    return 24'hFFFFFF;
            3'd2:    return 24'hFF0000;
            3'd3:    return 24'h00FF00;
            3'd4:    return 24'h0000FF;
            3'd5:    return 24'hFFFF00;
            3'd6:    return 24'h808080;
            default: return 24'h00FFFF;
        endcase
    endfunction

    // Stage 0: raster counters, incremental address, sprite shadow registers
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [N_SPR*XW-1:0] sx_q, sx_d;
    logic [N_SPR*YW-1:0] sy_q, sy_d;
    logic [N_SPR*3-1:0]  scor_q, scor_d;
    logic [N_SPR-1:0]    sact_q, sact_d;
    logic                first_px, last_px;

    logic                vld_p1_q, vld_p1_d;
    logic                last_p1_q, last_p1_d;
    logic [XW-1:0]       x_p1_q, x_p1_d;
    logic [YW-1:0]       y_p1_q, y_p1_d;

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        addr_d    = addr_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        scor_d    = scor_q;
        sact_d    = sact_q;
        first_px  = (x_q == '0) && (y_q == '0);
        last_px   = (x_q == X_LAST) && (y_q == Y_LAST);
        vld_p1_d  = pix_en;
        last_p1_d = pix_en && last_px;
        x_p1_d    = x_q;
        y_p1_d    = y_q;
        if (pix_en) begin
            // Sprite positions are frozen for the whole frame from its first pixel
            if (first_px) begin
                sx_d   = spr_x;
                sy_d   = spr_y;
                scor_d = spr_cor;
                sact_d = spr_ativo;
            end
            if (last_px) begin
                x_d    = '0;
                y_d    = '0;
                addr_d = '0;
            end else begin
                addr_d = addr_q + AW'(1);
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + YW'(1);
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
        end
    end

    // Stage 1: hit test against shadows, priority select, collision terms
    logic [N_SPR-1:0] hit_p1;
    logic [2:0]       idx_p1;
    logic [N_SPR-2:0] term_p1;

    always_comb begin
        hit_p1 = '0;
        idx_p1 = fundo;
        // Walk from highest index down so the lowest hitting sprite is assigned last
        for (int i = N_SPR - 1; i >= 0; i--) begin
            hit_p1[i] = sact_q[i]
                && (x_p1_q >= sx_q[i*XW +: XW])
                && ({1'b0, x_p1_q} < ({1'b0, sx_q[i*XW +: XW]} + SPR_W_E))
                && (y_p1_q >= sy_q[i*YW +: YW])
                && ({1'b0, y_p1_q} < ({1'b0, sy_q[i*YW +: YW]} + SPR_H_E));
            if (hit_p1[i]) begin
                idx_p1 = scor_q[i*3 +: 3];
            end
        end
        term_p1 = hit_p1[N_SPR-1:1] & {(N_SPR-1){hit_p1[0]}};
    end

    // Stage 2: RGB output register, frame pulse, collision accumulation
    logic [23:0]      rgb_p2_q, rgb_p2_d;
    logic             vld_p2_q, vld_p2_d;
    logic             fim_p2_q, fim_p2_d;
    logic [N_SPR-2:0] acc_q, acc_d;
    logic [N_SPR-2:0] col_q, col_d;

    always_comb begin
        rgb_p2_d = rgb_p2_q;
        vld_p2_d = vld_p1_q;
        fim_p2_d = vld_p1_q && last_p1_q;
        acc_d    = acc_q;
        col_d    = col_q;
        if (vld_p1_q) begin
            rgb_p2_d = palette(idx_p1);
            // Last pixel's own term goes into the report, never into the next frame
            if (last_p1_q) begin
                col_d = acc_q | term_p1;
                acc_d = '0;
            end else begin
                acc_d = acc_q | term_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q       <= '0;
            y_q       <= '0;
            addr_q    <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            scor_q    <= '0;
            sact_q    <= '0;
            vld_p1_q  <= 1'b0;
            last_p1_q <= 1'b0;
            x_p1_q    <= '0;
            y_p1_q    <= '0;
            rgb_p2_q  <= '0;
            vld_p2_q  <= 1'b0;
            fim_p2_q  <= 1'b0;
            acc_q     <= '0;
            col_q     <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            addr_q    <= addr_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            scor_q    <= scor_d;
            sact_q    <= sact_d;
            vld_p1_q  <= vld_p1_d;
            last_p1_q <= last_p1_d;
            x_p1_q    <= x_p1_d;
            y_p1_q    <= y_p1_d;
            rgb_p2_q  <= rgb_p2_d;
            vld_p2_q  <= vld_p2_d;
            fim_p2_q  <= fim_p2_d;
            acc_q     <= acc_d;
            col_q     <= col_d;
        end
    end

    assign endereco   = addr_q;
    assign data_out   = rgb_p2_q;
    assign data_valid = vld_p2_q;
    assign frame_fim  = fim_p2_q;
    assign colisao    = col_q;

endmodule

// File: tb/tb_compositor_sprites.sv
// Bench for compositor_sprites on a reduced 128x64 raster: per-pixel scoreboard from a
// behavioural model plus a table of hand-derived probe pixels.
module tb_compositor_sprites;
    localparam int H = 128, V = 64, N = 4, SW = 32, SH = 48, XW = 7, YW = 6, AW = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic            pix_en;
    logic [N*XW-1:0] spr_x;
    logic [N*YW-1:0] spr_y;
    logic [N*3-1:0]  spr_cor;
    logic [N-1:0]    spr_ativo;
    logic [AW-1:0]   endereco;
    logic [2:0]      fundo;
    logic [23:0]     data_out;
    logic            data_valid;
    logic            frame_fim;
    logic [N-2:0]    colisao;

    compositor_sprites #(
        .H_ATIVO(H), .V_ATIVO(V), .N_SPR(N), .SPR_W(SW), .SPR_H(SH),
        .XW(XW), .YW(YW), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .spr_x(spr_x), .spr_y(spr_y), .spr_cor(spr_cor), .spr_ativo(spr_ativo),
        .endereco(endereco), .fundo(fundo),
        .data_out(data_out), .data_valid(data_valid), .frame_fim(frame_fim),
        .colisao(colisao)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous background memory: index is either a constant or the address low bits
    logic [2:0] bg_const;
    logic       bg_pat;
    always @(posedge clk) fundo <= bg_pat ? endereco[2:0] : bg_const;

    localparam logic [23:0] PAL [8] = '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
                                        24'h0000FF, 24'hFFFF00, 24'h808080, 24'h00FFFF};

    typedef struct {
        logic [23:0] rgb;
        logic        last;
        logic [N-2:0] col;
        int          cyc;
        logic        probe;
        logic [23:0] prgb;
    } exp_t;

    typedef struct {
        int          fr;
        int          x;
        int          y;
        logic [23:0] rgb;
    } probe_t;

    exp_t   q[$];
    exp_t   ce;
    probe_t probes[16];

    int n_cmp = 0, n_fail = 0, fim_cnt = 0, probe_hits = 0;
    int mx = 0, my = 0, fr = 0;
    logic [N-2:0]    acc = '0, col_exp = '0;
    logic [23:0]     prev_rgb = '0;
    logic [N*XW-1:0] sh_x = '0;
    logic [N*YW-1:0] sh_y = '0;
    logic [N*3-1:0]  sh_c = '0;
    logic [N-1:0]    sh_a = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int c, input int a);
        spr_x[i*XW +: XW]  = XW'(x);
        spr_y[i*YW +: YW]  = YW'(y);
        spr_cor[i*3 +: 3]  = 3'(c);
        spr_ativo[i]       = 1'(a);
    endtask

    // One cycle of stimulus; called and returns at #1 after a rising edge
    task automatic step(input bit bub);
        logic         en;
        logic [N-1:0] h;
        logic [2:0]   idx;
        logic [N-2:0] term;
        int           addr, sx, sy;
        exp_t         e;
        en = bub ? ($urandom_range(0, 7) != 0) : 1'b1;
        pix_en = en;
        if (en) begin
            addr = my * H + mx;
            chk("endereco", 32'(endereco), addr);
            if (mx == 0 && my == 0) begin
                sh_x = spr_x; sh_y = spr_y; sh_c = spr_cor; sh_a = spr_ativo;
            end
            idx = bg_pat ? 3'(addr % 8) : bg_const;
            h = '0;
            for (int i = N - 1; i >= 0; i--) begin
                sx = int'(sh_x[i*XW +: XW]);
                sy = int'(sh_y[i*YW +: YW]);
                h[i] = sh_a[i] && mx >= sx && mx < sx + SW && my >= sy && my < sy + SH;
                if (h[i]) idx = sh_c[i*3 +: 3];
            end
            term    = h[N-1:1] & {(N-1){h[0]}};
            e.rgb   = PAL[idx];
            e.last  = (mx == H - 1) && (my == V - 1);
            e.cyc   = cyc;
            e.probe = 1'b0;
            e.prgb  = '0;
            if (e.last) begin
                e.col = acc | term;
                acc   = '0;
            end else begin
                acc   = acc | term;
                e.col = '0;
            end
            for (int p = 0; p < 16; p++)
                if (probes[p].fr == fr && probes[p].x == mx && probes[p].y == my) begin
                    e.probe = 1'b1;
                    e.prgb  = probes[p].rgb;
                end
            q.push_back(e);
            if (e.last) begin
                mx = 0; my = 0; fr++;
            end else if (mx == H - 1) begin
                mx = 0; my++;
            end else begin
                mx++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run_n(input int n);
        repeat (n) step(1'b0);
        pix_en = 1'b0;
    endtask

    task automatic run_until(input int tx, input int ty, input bit bub);
        while (!(mx == tx && my == ty)) step(bub);
        pix_en = 1'b0;
    endtask

    task automatic idle(input int n);
        pix_en = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int next_fr);
        pix_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("rst_endereco", 32'(endereco), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_data_valid", 32'(data_valid), 0);
        chk("rst_frame_fim", 32'(frame_fim), 0);
        chk("rst_colisao", 32'(colisao), 0);
        q.delete();
        prev_rgb = '0; col_exp = '0; acc = '0; mx = 0; my = 0; fr = next_fr;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (frame_fim) fim_cnt++;
            if (data_valid) begin
                if (q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL unexpected_valid: got data_valid=1 with nothing outstanding");
                end else begin
                    ce = q.pop_front();
                    if (ce.last) col_exp = ce.col;
                    chk("rgb", 32'(data_out), 32'(ce.rgb));
                    chk("latency", cyc, ce.cyc + 2);
                    chk("frame_fim", 32'(frame_fim), 32'(ce.last));
                    chk("colisao", 32'(colisao), 32'(col_exp));
                    if (ce.probe) begin
                        chk("probe", 32'(data_out), 32'(ce.prgb));
                        probe_hits++;
                    end
                    prev_rgb = data_out;
                end
            end else begin
                chk("fim_without_valid", 32'(frame_fim), 0);
                chk("hold", 32'(data_out), 32'(prev_rgb));
            end
        end
    end

    initial begin
        probes = '{
            '{0, 55, 30, 24'hFF0000}, '{0, 80, 30, 24'h0000FF}, '{0, 100, 30, 24'h808080},
            '{0, 125, 60, 24'hFFFF00}, '{0, 5, 60, 24'h808080},
            '{1, 20, 10, 24'h00FF00}, '{1, 35, 20, 24'h00FF00}, '{1, 50, 20, 24'h00FFFF},
            '{1, 90, 20, 24'hFF0000},
            '{2, 15, 40, 24'h00FF00}, '{2, 65, 40, 24'h808080},
            '{3, 65, 40, 24'h00FF00}, '{3, 15, 40, 24'h808080}, '{3, 85, 20, 24'h00FF00},
            '{3, 95, 20, 24'h00FFFF},
            '{5, 65, 40, 24'h00FF00}
        };
        reset = 1'b1; pix_en = 1'b0;
        spr_x = '0; spr_y = '0; spr_cor = '0; spr_ativo = '0;
        bg_const = 3'd1; bg_pat = 1'b0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_endereco", 32'(endereco), 0);
        chk("init_data_out", 32'(data_out), 0);
        chk("init_data_valid", 32'(data_valid), 0);
        chk("init_frame_fim", 32'(frame_fim), 0);
        chk("init_colisao", 32'(colisao), 0);
        reset = 1'b1;

        // Three pixels on a white background, then drain
        run_n(3);
        idle(4);
        chk("first3_drained", q.size(), 0);
        do_reset(0);

        // Frame A: overlapping player/opponent and a sprite clipped at right/bottom
        bg_const = 3'd6;
        set_spr(0, 40, 20, 2, 1);
        set_spr(1, 50, 20, 4, 1);
        set_spr(2, 0, 0, 0, 0);
        set_spr(3, 120, 40, 5, 1);
        run_n(H);
        chk("endereco_row1", 32'(endereco), H);
        run_until(0, 40, 1'b1);
        set_spr(0, 10, 5, 3, 1);
        set_spr(1, 100, 5, 4, 1);
        set_spr(2, 30, 15, 7, 1);
        set_spr(3, 0, 0, 0, 0);
        run_until(0, 0, 1'b1);

        // Frame B: patterned background, player overlaps sprite 2
        bg_pat = 1'b1;
        run_until(0, 1, 1'b0);
        chk("colisao_A", 32'(colisao), 32'b001);
        chk("fim_cnt_A", fim_cnt, 1);
        run_until(0, 40, 1'b0);
        set_spr(2, 80, 10, 7, 1);
        run_until(0, 0, 1'b0);

        // Frame C: sprite 2 moved away; player x changed mid-frame
        bg_pat = 1'b0;
        run_until(0, 1, 1'b0);
        chk("colisao_B", 32'(colisao), 32'b010);
        chk("fim_cnt_B", fim_cnt, 2);
        run_until(0, 32, 1'b0);
        set_spr(0, 60, 5, 3, 1);
        run_until(0, 0, 1'b0);

        // Frame D: new player x takes effect
        run_until(0, 1, 1'b0);
        chk("colisao_C", 32'(colisao), 32'b000);
        chk("fim_cnt_C", fim_cnt, 3);
        run_until(0, 0, 1'b0);

        // Frame E: interrupted by reset partway through
        run_until(0, 1, 1'b0);
        chk("colisao_D", 32'(colisao), 32'b010);
        chk("fim_cnt_D", fim_cnt, 4);
        run_until(64, 50, 1'b0);
        do_reset(5);
        chk("endereco_after_reset", 32'(endereco), 0);

        // Frame F: full frame after reset
        run_n(1);
        run_until(0, 0, 1'b0);
        idle(6);
        chk("colisao_F", 32'(colisao), 32'b010);
        chk("fim_cnt_F", fim_cnt, 5);
        chk("final_drained", q.size(), 0);
        chk("probe_hits", probe_hits, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
